tm_rs_seq: RTL

Sequencer for one RS encoder instance (CCSDS (255,223), dual-basis wrapper included) in the TM chain. Frames a byte stream into shortened codeblocks:
- Issues the encoder `start`.
- Injects virtual-fill zeros and suppresses them at the output.
- Gates the encoder `clkEn` for input starvation and output backpressure.
- Delivers data plus parity with sof/eof.

It sits between the TM frame buffer and the ASM/randomizer stage.

---
 rtl/tm_rs_pkg.sv | 30 +++
 rtl/tm_rs_tagpipe.sv | 34 +++
 rtl/tm_rs_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tm_rs_pkg.sv
// Shared constants, FSM state codes and the output tag type for the
// TM Reed-Solomon sequencer.
package tm_rs_pkg;

  // CCSDS (255,223) code over 8-bit symbols
  localparam int KK = 223;
  localparam int NN = 255;
  localparam int MM = 8;

  // Sequencer states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  // Per-symbol tag travelling alongside the encoder pipeline
  typedef struct packed {
    logic keep;  // symbol is transmitted
    logic sof;   // first transmitted symbol of a block
    logic eof;   // last parity symbol of a block
  } tag_t;

  // Virtual fill must leave at least one data symbol in the block
  function automatic logic [7:0] clamp_fill(input logic [7:0] f);
    return (f >= 8'(KK)) ? 8'(KK - 1) : f;
  endfunction

endpackage

// File: rtl/tm_rs_tagpipe.sv
// Enable-gated shift register of symbol tags, LAT deep, so the head tag
// lines up with the symbol the encoder presents on enc_dout.
module tm_rs_tagpipe
  import tm_rs_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic nGrst,
  input  logic clr,
  input  logic en,
  input  tag_t tag_in,
  output tag_t head
);

  tag_t pipe [LAT];

  // Advance the tag pipe only when the encoder advances.
  // NOTE: this small array is reset on purpose; a stale keep bit after
  // reset or a mid-block clear would emit a spurious out_valid.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= tag_in;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head = pipe[LAT-1];

endmodule

// File: rtl/tm_rs_seq.sv
// Sequencer for one RS(255,223) encoder: frames the input byte stream into
// shortened codeblocks, injects and hides virtual fill, gates the encoder
// clock enable for starvation/backpressure and tags sof/eof on the output.
module tm_rs_seq
  import tm_rs_pkg::*;
#(
  parameter int LAT = 2  // encoder latency in enabled cycles (2..4)
) (
  input  logic          clk,
  input  logic          nGrst,
  input  logic          rst,
  input  logic [7:0]    cfg_fill,
  input  logic [MM-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          enc_rst,
  output logic          enc_clkEn,
  output logic          enc_start,
  output logic [MM-1:0] enc_din,
  input  logic          enc_rfs,
  input  logic [MM-1:0] enc_dout,
  output logic [MM-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eof,
  output logic          busy,
  output logic [15:0]   blk_cnt
);

  logic [2:0] state;
  logic [7:0] sym_cnt;   // symbols left in the current state
  logic [7:0] fill_q;    // virtual fill count for the current block
  logic [7:0] data_len;
  logic       step_ok;
  logic       en;
  logic       last_step;
  tag_t       tag_in;
  tag_t       head;

  assign data_len = 8'(KK) - fill_q;

  // Decide whether the current state has a symbol to push this cycle.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    step_ok = 1'b0;
    case (state)
      S_START, S_FILL, S_PARITY, S_FLUSH: step_ok = 1'b1;
      S_DATA:                             step_ok = in_valid;
      default:                            step_ok = 1'b0;
    endcase
  end

  // The encoder only steps when the output slot is free or being emptied,
  // which freezes enc_dout (and hence out_data) under backpressure.
  assign en        = ~rst & step_ok & (out_ready | ~out_valid);
  assign last_step = en & (sym_cnt == 8'd1);

  assign enc_rst   = rst;
  assign enc_clkEn = en;
  assign enc_start = en & (state == S_START);
  assign in_ready  = en & (state == S_DATA);
  assign enc_din   = in_ready ? in_data : '0;
  assign out_data  = enc_dout;
  assign busy      = ~rst & (state != S_IDLE);

  // Tag the symbol entering the encoder this cycle.
  always_comb begin
    tag_in      = '0;
    tag_in.keep = (state == S_DATA) || (state == S_PARITY);
    tag_in.sof  = (state == S_DATA) && (sym_cnt == data_len);
    tag_in.eof  = (state == S_PARITY) && (sym_cnt == 8'd1);
  end

  // Block FSM with a single down-counter reloaded on each state entry.
  // NOTE: state registers use non-blocking assignments so every branch
  // reads the pre-edge values of state and sym_cnt.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state   <= S_IDLE;
      sym_cnt <= '0;
      fill_q  <= '0;
    end else if (rst) begin
      state   <= S_IDLE;
      sym_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && enc_rfs) begin
            state   <= S_START;
            sym_cnt <= 8'd1;
            fill_q  <= clamp_fill(cfg_fill);
          end
        end
        S_START: begin
          if (en) begin
            if (fill_q != 8'd0) begin
              state   <= S_FILL;
              sym_cnt <= fill_q;
            end else begin
              state   <= S_DATA;
              sym_cnt <= data_len;
            end
          end
        end
        S_FILL: begin
          if (last_step) begin
            state   <= S_DATA;
            sym_cnt <= data_len;
          end else if (en) begin
            sym_cnt <= sym_cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (last_step) begin
            state   <= S_PARITY;
            sym_cnt <= 8'(NN - KK);
          end else if (en) begin
            sym_cnt <= sym_cnt - 8'd1;
          end
        end
        S_PARITY: begin
          if (last_step) begin
            state   <= S_FLUSH;
            sym_cnt <= 8'(LAT);
          end else if (en) begin
            sym_cnt <= sym_cnt - 8'd1;
          end
        end
        S_FLUSH: begin
          if (last_step) begin
            state   <= S_IDLE;
            sym_cnt <= '0;
          end else if (en) begin
            sym_cnt <= sym_cnt - 8'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          sym_cnt <= '0;
        end
      endcase
    end
  end

  // Count completed blocks; survives the synchronous clear.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      blk_cnt <= '0;
    end else if ((state == S_FLUSH) && last_step) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end

  tm_rs_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk    (clk),
    .nGrst  (nGrst),
    .clr    (rst),
    .en     (en),
    .tag_in (tag_in),
    .head   (head)
  );

  // Output slot: load a kept symbol when the encoder steps, else drain on accept.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en && head.keep) begin
      out_valid <= 1'b1;
      out_sof   <= head.sof;
      out_eof   <= head.eof;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end
  end

endmodule
